// File: rtl/alu_result_fifo.sv
// Capture stage for the 8-bit ALU: registers each valid result with derived flags
// and buffers it in a DEPTH-entry FIFO drained through a valid/ready handshake.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    alu_out,
  input  logic          alu_cout,
  input  logic [3:0]    alu_opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_cout,
  output logic          out_zero,
  output logic          out_neg,
  output logic          out_ill,
  output logic [3:0]    out_opcode,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          clr_ovf
);

  typedef struct packed {
    logic [3:0] opcode;
    logic       cout;
    logic [7:0] data;
    logic       zero;
    logic       neg;
    logic       ill;
  } entry_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  entry_t          mem_q [DEPTH];
  entry_t          entry_d;
  entry_t          head;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;

  always_comb begin
    entry_d        = '0;
    entry_d.opcode = alu_opcode;
    entry_d.cout   = alu_cout;
    entry_d.data   = alu_out;
    entry_d.zero   = (alu_out == 8'h00);
    entry_d.neg    = alu_out[7];
    // Legal opcodes are exactly 01xx and 11xx, so bit 2 alone decides legality.
    entry_d.ill    = ~alu_opcode[2];

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (clr_ovf)           ovf_d = 1'b0;
    if (in_valid && full)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= entry_d;
  end

  // Storage is never cleared, so head fields are masked whenever nothing is held.
  assign head       = mem_q[rptr_q];
  assign out_valid  = ~empty;
  assign in_ready   = ~full;
  assign out_data   = empty ? 8'h00 : head.data;
  assign out_cout   = empty ? 1'b0  : head.cout;
  assign out_zero   = empty ? 1'b0  : head.zero;
  assign out_neg    = empty ? 1'b0  : head.neg;
  assign out_ill    = empty ? 1'b0  : head.ill;
  assign out_opcode = empty ? 4'h0  : head.opcode;
  assign count      = count_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: hand-computed expectations for capture flags,
// full/overflow handling, streaming push+pop, and asynchronous reset.
module tb_alu_result_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic [3:0] alu_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_cout;
  logic       out_zero;
  logic       out_neg;
  logic       out_ill;
  logic [3:0] out_opcode;
  logic [2:0] count;
  logic       ovf;
  logic       clr_ovf;

  int total_checks = 0;
  int bad_checks   = 0;

  alu_result_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_opcode (alu_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cout   (out_cout),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ill    (out_ill),
    .out_opcode (out_opcode),
    .count      (count),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [7:0] d,
                               input logic c, input logic rdy, input logic clr);
    in_valid   = v;
    alu_opcode = op;
    alu_out    = d;
    alu_cout   = c;
    out_ready  = rdy;
    clr_ovf    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] drain_vals [4];

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    // Reset state
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_count",     32'(count),     32'd0);
    checkOutput("rst_ovf",       32'(ovf),       32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'h00);
    #10;
    rst_n = 1'b1;
    tick();
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

    // Single push with zero result, legal opcode
    applyStimulus(1'b1, 4'b1111, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("t2_out_valid", 32'(out_valid),  32'd1);
    checkOutput("t2_out_data",  32'(out_data),   32'h00);
    checkOutput("t2_out_cout",  32'(out_cout),   32'd1);
    checkOutput("t2_out_zero",  32'(out_zero),   32'd1);
    checkOutput("t2_out_neg",   32'(out_neg),    32'd0);
    checkOutput("t2_out_ill",   32'(out_ill),    32'd0);
    checkOutput("t2_opcode",    32'(out_opcode), 32'hF);
    checkOutput("t2_count",     32'(count),      32'd1);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t2_pop_count", 32'(count),     32'd0);
    checkOutput("t2_pop_valid", 32'(out_valid), 32'd0);
    checkOutput("t2_pop_data",  32'(out_data),  32'h00);
    tick();
    idle();
    checkOutput("empty_pop_count", 32'(count), 32'd0);

    // Fill to full, overflow with simultaneous clear (set wins)
    drain_vals[0] = 8'h80; drain_vals[1] = 8'h01; drain_vals[2] = 8'h02; drain_vals[3] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'b0110, drain_vals[i], 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("t3_in_ready_full", 32'(in_ready), 32'd0);
    checkOutput("t3_count_full",    32'(count),    32'd4);
    checkOutput("t3_ovf_before",    32'(ovf),      32'd0);
    applyStimulus(1'b1, 4'b0110, 8'h04, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("t3_ovf_set",    32'(ovf),      32'd1);
    checkOutput("t3_count_drop", 32'(count),    32'd4);
    checkOutput("t3_head",       32'(out_data), 32'h80);
    checkOutput("t3_head_neg",   32'(out_neg),  32'd1);
    // Pop while full with in_valid: no push this cycle
    applyStimulus(1'b1, 4'b0110, 8'h05, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("t3_popfull_count", 32'(count),    32'd3);
    checkOutput("t3_popfull_ready", 32'(in_ready), 32'd1);
    checkOutput("t3_ovf_sticky",    32'(ovf),      32'd1);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("t3_drain%0d", i), 32'(out_data), 32'(drain_vals[i]));
      checkOutput($sformatf("t3_neg%0d", i),   32'(out_neg),  32'd0);
      applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
    end
    checkOutput("t3_empty", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("t3_ovf_clr", 32'(ovf), 32'd0);

    // Streaming push+pop, pointers wrap repeatedly
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'b0100, 8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("t4_data%0d", i),  32'(out_data), 32'h10 + 32'(i));
      checkOutput($sformatf("t4_count%0d", i), 32'(count),    32'd1);
    end
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("t4_final_count", 32'(count), 32'd0);

    // Illegal opcode still stored
    applyStimulus(1'b1, 4'b1011, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("t5_ill",    32'(out_ill),    32'd1);
    checkOutput("t5_zero",   32'(out_zero),   32'd1);
    checkOutput("t5_opcode", 32'(out_opcode), 32'hB);
    applyStimulus(1'b1, 4'b0000, 8'h7F, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("t5_op0_ill",  32'(out_ill),  32'd1);
    checkOutput("t5_op0_data", 32'(out_data), 32'h7F);
    checkOutput("t5_op0_zero", 32'(out_zero), 32'd0);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    idle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b1100, 8'hA1 + 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    checkOutput("t6_count3", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_async_count", 32'(count),     32'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0100, 8'hC5, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("t6_after_count", 32'(count),      32'd1);
    checkOutput("t6_after_data",  32'(out_data),   32'hC5);
    checkOutput("t6_after_neg",   32'(out_neg),    32'd1);
    checkOutput("t6_after_cout",  32'(out_cout),   32'd1);
    checkOutput("t6_after_ill",   32'(out_ill),    32'd0);
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("t6_sole_entry", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
